// File: rtl/leds_dec_pkg.sv
// Shared definitions for the LED bus state decoder: the eleven legal LED
// patterns, the pattern classes, the decoder FSM states and the mapping
// from a position pattern to a signed rope position.
package leds_dec_pkg;

    localparam logic [6:0] PAT_RST   = 7'b1100011;
    localparam logic [6:0] PAT_BLANK = 7'b0000000;
    localparam logic [6:0] PAT_L3    = 7'b1000000;
    localparam logic [6:0] PAT_L2    = 7'b0100000;
    localparam logic [6:0] PAT_L1    = 7'b0010000;
    localparam logic [6:0] PAT_N     = 7'b0001000;
    localparam logic [6:0] PAT_R1    = 7'b0000100;
    localparam logic [6:0] PAT_R2    = 7'b0000010;
    localparam logic [6:0] PAT_R3    = 7'b0000001;
    localparam logic [6:0] PAT_WINL  = 7'b1110000;
    localparam logic [6:0] PAT_WINR  = 7'b0000111;

    typedef enum logic [2:0] {
        CLS_RST   = 3'd0,
        CLS_BLANK = 3'd1,
        CLS_POS   = 3'd2,
        CLS_WINL  = 3'd3,
        CLS_WINR  = 3'd4,
        CLS_BAD   = 3'd5
    } pat_cls_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_WIN_L = 2'd2,
        ST_WIN_R = 2'd3
    } dec_state_e;

    // Rope position of a single-LED pattern: -3 (L3) .. 0 (N) .. +3 (R3).
    // Non-position patterns map to 0; callers qualify with the class.
    function automatic logic signed [2:0] pat_to_pos(input logic [6:0] pat);
        case (pat)
            PAT_L3:  return 3'sb101;
            PAT_L2:  return 3'sb110;
            PAT_L1:  return 3'sb111;
            PAT_N:   return 3'sb000;
            PAT_R1:  return 3'sb001;
            PAT_R2:  return 3'sb010;
            PAT_R3:  return 3'sb011;
            default: return 3'sb000;
        endcase
    endfunction

endpackage

// File: rtl/leds_stable_filter.sv
// Glitch filter for the LED bus: registers the raw pattern, counts how many
// consecutive samples it has stayed unchanged and raises a single-cycle
// accept strobe when that run reaches exactly STABLE_CYCLES.
module leds_stable_filter
    import leds_dec_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] leds_i,
    output logic [6:0] acc_pat,
    output logic       acc_stb
);

    localparam logic [7:0] RUN_TARGET = 8'(STABLE_CYCLES);

    logic [6:0] samp_q;
    logic [7:0] cnt_q, cnt_d;
    logic       stb_q, stb_d;
    logic       same_s;

    // Run-length update; the counter parks at the target so the strobe
    // fires only once per run no matter how long the pattern is held.
    always_comb begin
        same_s = (leds_i == samp_q);
        cnt_d  = 8'd1;
        if (same_s) begin
            if (cnt_q == RUN_TARGET) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = 8'd1;
        end
        stb_d = (cnt_d == RUN_TARGET) && !(same_s && (cnt_q == RUN_TARGET));
    end

    // Sample register, run counter and accept strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            samp_q <= PAT_RST;
            cnt_q  <= 8'd0;
            stb_q  <= 1'b0;
        end else begin
            samp_q <= leds_i;
            cnt_q  <= cnt_d;
            stb_q  <= stb_d;
        end
    end

    assign acc_pat = samp_q;
    assign acc_stb = stb_q;

endmodule

// File: rtl/leds_state_decoder.sv
// Observer for the tug-of-war LED bus. Filters the 7-bit pattern, classifies
// each accepted pattern and tracks game state: rope position, win levels,
// saturating round tallies and protocol-violation pulses.
// Build option LEDS_DEC_BLINK_EN: when defined, BLANK frames are legal in
// every state (game blinking); otherwise BLANK is legal only in IDLE.
module leds_state_decoder
    import leds_dec_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ROUND_W       = 4
) (
    input  logic                CLK_I,
    input  logic                rst,
    input  logic [6:0]          leds_in,
    output logic signed [2:0]   pos,
    output logic                pos_valid,
    output logic                step_evt,
    output logic                win_l,
    output logic                win_r,
    output logic [ROUND_W-1:0]  rounds_l,
    output logic [ROUND_W-1:0]  rounds_r,
    output logic                illegal
);

`ifdef LEDS_DEC_BLINK_EN
    localparam logic BLANK_OK = 1'b1;
`else
    localparam logic BLANK_OK = 1'b0;
`endif

    localparam logic signed [2:0] POS_MIN = 3'sb101;
    localparam logic signed [2:0] POS_MAX = 3'sb011;
    localparam logic [ROUND_W-1:0] ROUND_SAT = {ROUND_W{1'b1}};

    function automatic pat_cls_e classify(input logic [6:0] pat);
        case (pat)
            PAT_RST:   return CLS_RST;
            PAT_BLANK: return CLS_BLANK;
            PAT_L3, PAT_L2, PAT_L1, PAT_N,
            PAT_R1, PAT_R2, PAT_R3: return CLS_POS;
            PAT_WINL:  return CLS_WINL;
            PAT_WINR:  return CLS_WINR;
            default:   return CLS_BAD;
        endcase
    endfunction

    logic [6:0]          acc_pat_s;
    logic                acc_stb_s;
    pat_cls_e            cls_s;
    logic signed [2:0]   acc_pos_s;
    logic signed [3:0]   diff_s;

    dec_state_e          state_q, state_d;
    logic signed [2:0]   pos_q, pos_d;
    logic                pos_valid_q, pos_valid_d;
    logic                step_q, step_d;
    logic                ill_q, ill_d;
    logic                win_l_q, win_l_d;
    logic                win_r_q, win_r_d;
    logic [ROUND_W-1:0]  rl_q, rl_d;
    logic [ROUND_W-1:0]  rr_q, rr_d;

    leds_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk_i   (CLK_I),
        .rst_ni  (rst),
        .leds_i  (leds_in),
        .acc_pat (acc_pat_s),
        .acc_stb (acc_stb_s)
    );

    assign cls_s     = classify(acc_pat_s);
    assign acc_pos_s = pat_to_pos(acc_pat_s);
    assign diff_s    = {acc_pos_s[2], acc_pos_s} - {pos_q[2], pos_q};

    // Next-state, position, round tallies and event pulses per accepted pattern.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        ill_d   = 1'b0;
        rl_d    = rl_q;
        rr_d    = rr_q;
        if (acc_stb_s) begin
            case (state_q)
                ST_IDLE: begin
                    case (cls_s)
                        CLS_POS: begin
                            if (acc_pos_s == 3'sb000) begin
                                state_d = ST_PLAY;
                                pos_d   = 3'sb000;
                            end else begin
                                ill_d = 1'b1;
                            end
                        end
                        CLS_RST, CLS_BLANK: ill_d = 1'b0;
                        default:            ill_d = 1'b1;
                    endcase
                end
                ST_PLAY: begin
                    case (cls_s)
                        CLS_POS: begin
                            if (diff_s == 4'sd0) begin
                                step_d = 1'b0;
                            end else if ((diff_s == 4'sd1) || (diff_s == -4'sd1)) begin
                                step_d = 1'b1;
                                pos_d  = acc_pos_s;
                            end else begin
                                // A jump is still tracked so the observer stays in sync.
                                step_d = 1'b1;
                                ill_d  = 1'b1;
                                pos_d  = acc_pos_s;
                            end
                        end
                        CLS_WINL: begin
                            if (pos_q == POS_MIN) begin
                                state_d = ST_WIN_L;
                                if (rl_q != ROUND_SAT) begin
                                    rl_d = rl_q + ROUND_W'(1);
                                end else begin
                                    rl_d = rl_q;
                                end
                            end else begin
                                ill_d = 1'b1;
                            end
                        end
                        CLS_WINR: begin
                            if (pos_q == POS_MAX) begin
                                state_d = ST_WIN_R;
                                if (rr_q != ROUND_SAT) begin
                                    rr_d = rr_q + ROUND_W'(1);
                                end else begin
                                    rr_d = rr_q;
                                end
                            end else begin
                                ill_d = 1'b1;
                            end
                        end
                        CLS_RST:   state_d = ST_IDLE;
                        CLS_BLANK: ill_d   = ~BLANK_OK;
                        default:   ill_d   = 1'b1;
                    endcase
                end
                ST_WIN_L: begin
                    case (cls_s)
                        CLS_RST:   state_d = ST_IDLE;
                        CLS_WINL:  ill_d   = 1'b0;
                        CLS_BLANK: ill_d   = ~BLANK_OK;
                        default:   ill_d   = 1'b1;
                    endcase
                end
                ST_WIN_R: begin
                    case (cls_s)
                        CLS_RST:   state_d = ST_IDLE;
                        CLS_WINR:  ill_d   = 1'b0;
                        CLS_BLANK: ill_d   = ~BLANK_OK;
                        default:   ill_d   = 1'b1;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
        pos_valid_d = (state_d == ST_PLAY);
        win_l_d     = (state_d == ST_WIN_L);
        win_r_d     = (state_d == ST_WIN_R);
    end

    // State and registered outputs.
    always_ff @(posedge CLK_I or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pos_q       <= 3'sb000;
            pos_valid_q <= 1'b0;
            step_q      <= 1'b0;
            ill_q       <= 1'b0;
            win_l_q     <= 1'b0;
            win_r_q     <= 1'b0;
            rl_q        <= '0;
            rr_q        <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            step_q      <= step_d;
            ill_q       <= ill_d;
            win_l_q     <= win_l_d;
            win_r_q     <= win_r_d;
            rl_q        <= rl_d;
            rr_q        <= rr_d;
        end
    end

    assign pos       = pos_q;
    assign pos_valid = pos_valid_q;
    assign step_evt  = step_q;
    assign illegal   = ill_q;
    assign win_l     = win_l_q;
    assign win_r     = win_r_q;
    assign rounds_l  = rl_q;
    assign rounds_r  = rr_q;

endmodule
